// File: rtl/instr_decode_queue.sv
// 6502 instruction assembler/decoder: collects opcode + operand bytes and queues decoded entries.
// Optional DECODE_ILLEGAL_TRAP_EN: unsupported opcodes report class 12 instead of NOP (0).
module instr_decode_queue #(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic [7:0]       byte_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_opcode,
    output logic [15:0]      out_operand,
    output logic [1:0]       out_len,
    output logic [3:0]       out_class,
    output logic [2:0]       out_regs,
    output logic [3:0]       out_flags,
    output logic [1:0]       out_mem,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    localparam logic [3:0] C_LOAD     = 4'd1;
    localparam logic [3:0] C_STORE    = 4'd2;
    localparam logic [3:0] C_ARITH    = 4'd3;
    localparam logic [3:0] C_LOGIC    = 4'd4;
    localparam logic [3:0] C_BRANCH   = 4'd6;
    localparam logic [3:0] C_JUMP     = 4'd7;
    localparam logic [3:0] C_TRANSFER = 4'd8;
    localparam logic [3:0] C_COMPARE  = 4'd9;
    localparam logic [3:0] C_FLAG     = 4'd10;
    localparam logic [3:0] C_STACK    = 4'd11;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic [3:0] C_UNSUP    = 4'd12;
`else
    localparam logic [3:0] C_UNSUP    = 4'd0;
`endif

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_NZ   = 4'b1100;
    localparam logic [3:0] F_NZC  = 4'b1110;
    localparam logic [3:0] F_NZCV = 4'b1111;
    localparam logic [3:0] F_C    = 4'b0010;

    localparam logic [1:0] M_NONE = 2'b00;
    localparam logic [1:0] M_RD   = 2'b10;
    localparam logic [1:0] M_WR   = 2'b01;
    localparam logic [1:0] M_RW   = 2'b11;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_A    = 3'b001;
    localparam logic [2:0] R_X    = 3'b010;
    localparam logic [2:0] R_Y    = 3'b100;
    localparam logic [2:0] R_AX   = 3'b011;
    localparam logic [2:0] R_AY   = 3'b101;
    localparam logic [2:0] R_XY   = 3'b110;

    typedef struct packed {
        logic [1:0] len;
        logic [3:0] cls;
        logic [2:0] regs;
        logic [3:0] flags;
        logic [1:0] mem;
    } dec_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] operand;
        dec_t        dec;
    } entry_t;

    typedef enum logic [1:0] {S_OPC, S_OP1, S_OP2} state_t;

    function automatic dec_t decode_op(input logic [7:0] op);
        dec_t d;
        d = '0;
        // Column cc=01 is the regular ALU group; bbb selects the addressing mode.
        if (op[1:0] == 2'b01 && op != 8'h89) begin
            case (op[4:2])
                3'd0:       begin d.len = 2'd2; d.regs = R_X; end
                3'd1, 3'd2: d.len = 2'd2;
                3'd3:       d.len = 2'd3;
                3'd4:       begin d.len = 2'd2; d.regs = R_Y; end
                3'd5:       begin d.len = 2'd2; d.regs = R_X; end
                3'd6:       begin d.len = 2'd3; d.regs = R_Y; end
                default:    begin d.len = 2'd3; d.regs = R_X; end
            endcase
            d.regs = d.regs | R_A;
            d.mem  = M_RD;
            case (op[7:5])
                3'd3, 3'd7: begin d.cls = C_ARITH;   d.flags = F_NZCV; end
                3'd4:       begin d.cls = C_STORE;   d.mem   = M_WR;   end
                3'd5:       begin d.cls = C_LOAD;    d.flags = F_NZ;   end
                3'd6:       begin d.cls = C_COMPARE; d.flags = F_NZC;  end
                default:    begin d.cls = C_LOGIC;   d.flags = F_NZ;   end
            endcase
        end else begin
            case (op)
                8'hA2, 8'hA6: d = {2'd2, C_LOAD, R_X, F_NZ, M_RD};
                8'hB6:        d = {2'd2, C_LOAD, R_XY, F_NZ, M_RD};
                8'hAE:        d = {2'd3, C_LOAD, R_X, F_NZ, M_RD};
                8'hBE:        d = {2'd3, C_LOAD, R_XY, F_NZ, M_RD};
                8'hA0, 8'hA4: d = {2'd2, C_LOAD, R_Y, F_NZ, M_RD};
                8'hB4:        d = {2'd2, C_LOAD, R_XY, F_NZ, M_RD};
                8'hAC:        d = {2'd3, C_LOAD, R_Y, F_NZ, M_RD};
                8'hBC:        d = {2'd3, C_LOAD, R_XY, F_NZ, M_RD};
                8'h86:        d = {2'd2, C_STORE, R_X, F_NONE, M_WR};
                8'h96:        d = {2'd2, C_STORE, R_XY, F_NONE, M_WR};
                8'h8E:        d = {2'd3, C_STORE, R_X, F_NONE, M_WR};
                8'h84:        d = {2'd2, C_STORE, R_Y, F_NONE, M_WR};
                8'h94:        d = {2'd2, C_STORE, R_XY, F_NONE, M_WR};
                8'h8C:        d = {2'd3, C_STORE, R_Y, F_NONE, M_WR};
                8'hE0, 8'hE4: d = {2'd2, C_COMPARE, R_X, F_NZC, M_RD};
                8'hEC:        d = {2'd3, C_COMPARE, R_X, F_NZC, M_RD};
                8'hC0, 8'hC4: d = {2'd2, C_COMPARE, R_Y, F_NZC, M_RD};
                8'hCC:        d = {2'd3, C_COMPARE, R_Y, F_NZC, M_RD};
                8'hAA, 8'h8A: d = {2'd1, C_TRANSFER, R_AX, F_NZ, M_NONE};
                8'hA8, 8'h98: d = {2'd1, C_TRANSFER, R_AY, F_NZ, M_NONE};
                8'h10, 8'h30, 8'h50, 8'h70,
                8'h90, 8'hB0, 8'hD0, 8'hF0:
                              d = {2'd2, C_BRANCH, R_NONE, F_NONE, M_RD};
                8'h4C, 8'h6C: d = {2'd3, C_JUMP, R_NONE, F_NONE, M_RD};
                8'h20:        d = {2'd3, C_JUMP, R_NONE, F_NONE, M_RW};
                8'h60:        d = {2'd1, C_JUMP, R_NONE, F_NONE, M_RD};
                8'h18, 8'h38: d = {2'd1, C_FLAG, R_NONE, F_C, M_NONE};
                8'h48:        d = {2'd1, C_STACK, R_A, F_NONE, M_WR};
                8'h68:        d = {2'd1, C_STACK, R_A, F_NZ, M_RD};
                default:      d = {2'd1, C_UNSUP, R_NONE, F_NONE, M_NONE};
            endcase
        end
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       opc_q, opc_d;
    logic [7:0]       lo_q, lo_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [QDEPTH];

    logic       accept, push, pop;
    logic [7:0] op_sel;
    dec_t       dec;
    entry_t     push_entry, head;

    always_comb begin
        out_valid  = (count_q != '0);
        byte_ready = rst_n && !flush && ((count_q < DEPTH_C) || (out_valid && out_ready));
        accept     = byte_valid && byte_ready;
        pop        = out_valid && out_ready && !flush;
        op_sel     = (state_q == S_OPC) ? byte_data : opc_q;
        dec        = decode_op(op_sel);

        state_d            = state_q;
        opc_d              = opc_q;
        lo_d               = lo_q;
        push               = 1'b0;
        push_entry.opcode  = op_sel;
        push_entry.operand = 16'h0000;
        push_entry.dec     = dec;

        if (flush) begin
            state_d = S_OPC;
            opc_d   = 8'h00;
            lo_d    = 8'h00;
        end else if (accept) begin
            case (state_q)
                S_OPC: begin
                    if (dec.len == 2'd1) push = 1'b1;
                    else begin
                        opc_d   = byte_data;
                        state_d = S_OP1;
                    end
                end
                S_OP1: begin
                    if (dec.len == 2'd2) begin
                        push               = 1'b1;
                        push_entry.operand = {8'h00, byte_data};
                        state_d            = S_OPC;
                    end else begin
                        lo_d    = byte_data;
                        state_d = S_OP2;
                    end
                end
                default: begin
                    push               = 1'b1;
                    push_entry.operand = {byte_data, lo_q};
                    state_d            = S_OPC;
                end
            endcase
        end

        // Power-of-two depth lets the pointers wrap by plain overflow.
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OPC;
            opc_q    <= 8'h00;
            lo_q     <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            lo_q     <= lo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_comb begin
        head = out_valid ? mem_q[rd_ptr_q] : '0;
        out_opcode  = head.opcode;
        out_operand = head.operand;
        out_len     = head.dec.len;
        out_class   = head.dec.cls;
        out_regs    = head.dec.regs;
        out_flags   = head.dec.flags;
        out_mem     = head.dec.mem;
        count       = count_q;
    end
endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: directed vector table, corner sequences, random traffic vs queue model.
module tb_instr_decode_queue;
    localparam int QD = 4;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic [3:0] ILL_C = 4'd12;
`else
    localparam logic [3:0] ILL_C = 4'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        byte_ready, out_valid;
    logic [7:0]  out_opcode;
    logic [15:0] out_operand;
    logic [1:0]  out_len, out_mem;
    logic [3:0]  out_class, out_flags;
    logic [2:0]  out_regs;
    logic [2:0]  count;

    instr_decode_queue #(.QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_operand(out_operand), .out_len(out_len),
        .out_class(out_class), .out_regs(out_regs), .out_flags(out_flags),
        .out_mem(out_mem), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  opc;
        logic [15:0] opd;
        logic [1:0]  len;
        logic [3:0]  cls;
        logic [2:0]  regs;
        logic [3:0]  flg;
        logic [1:0]  mem;
    } ent_t;

    typedef enum {IMP, IMM, ZP, ZPX, ZPY, ABS, ABX, ABY, INX, INY, REL, IND} mode_t;

    typedef struct {
        logic [23:0] bytes;
        int          n;
        ent_t        exp;
    } vec_t;

    ent_t       dut_e;
    ent_t       ref_dec [256];
    ent_t       mq [$];
    logic [7:0] part [$];
    vec_t       vecs [13];
    int         n_chk = 0;
    int         n_pass = 0;

    assign dut_e = {out_opcode, out_operand, out_len, out_class, out_regs, out_flags, out_mem};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic def(input logic [7:0] op, input mode_t m, input logic [3:0] c,
                       input logic [2:0] r, input logic [3:0] f, input logic [1:0] mm);
        logic [1:0] ln;
        logic [2:0] ix;
        ln = (m == IMP) ? 2'd1 : (m == ABS || m == ABX || m == ABY || m == IND) ? 2'd3 : 2'd2;
        ix = (m == ZPX || m == ABX || m == INX) ? 3'b010 :
             (m == ZPY || m == ABY || m == INY) ? 3'b100 : 3'b000;
        ref_dec[op] = {op, 16'h0000, ln, c, r | ix, f, mm};
    endtask

    // Eight-opcode accumulator group, opcodes listed in the order IMM ZP ZPX ABS ABX ABY INX INY.
    task automatic grp(input logic [63:0] ops, input logic [3:0] c, input logic [3:0] f, input logic [1:0] mm);
        mode_t gm [8];
        gm = '{IMM, ZP, ZPX, ABS, ABX, ABY, INX, INY};
        for (int i = 0; i < 8; i++) def(ops[63-8*i -: 8], gm[i], c, 3'b001, f, mm);
    endtask

    task automatic setv(input int k, input logic [23:0] b, input int n, input ent_t e);
        vecs[k].bytes = b;
        vecs[k].n     = n;
        vecs[k].exp   = e;
    endtask

    task automatic build_ref();
        logic [63:0] br;
        for (int i = 0; i < 256; i++) ref_dec[i] = {8'(i), 16'h0000, 2'd1, ILL_C, 3'b000, 4'b0000, 2'b00};
        grp(64'h09_05_15_0D_1D_19_01_11, 4'd4, 4'b1100, 2'b10);
        grp(64'h29_25_35_2D_3D_39_21_31, 4'd4, 4'b1100, 2'b10);
        grp(64'h49_45_55_4D_5D_59_41_51, 4'd4, 4'b1100, 2'b10);
        grp(64'h69_65_75_6D_7D_79_61_71, 4'd3, 4'b1111, 2'b10);
        grp(64'hE9_E5_F5_ED_FD_F9_E1_F1, 4'd3, 4'b1111, 2'b10);
        grp(64'hA9_A5_B5_AD_BD_B9_A1_B1, 4'd1, 4'b1100, 2'b10);
        grp(64'hC9_C5_D5_CD_DD_D9_C1_D1, 4'd9, 4'b1110, 2'b10);
        def(8'h85, ZP, 4'd2, 3'b001, 4'b0, 2'b01);  def(8'h95, ZPX, 4'd2, 3'b001, 4'b0, 2'b01);
        def(8'h8D, ABS, 4'd2, 3'b001, 4'b0, 2'b01); def(8'h9D, ABX, 4'd2, 3'b001, 4'b0, 2'b01);
        def(8'h99, ABY, 4'd2, 3'b001, 4'b0, 2'b01); def(8'h81, INX, 4'd2, 3'b001, 4'b0, 2'b01);
        def(8'h91, INY, 4'd2, 3'b001, 4'b0, 2'b01);
        def(8'hA2, IMM, 4'd1, 3'b010, 4'b1100, 2'b10); def(8'hA6, ZP, 4'd1, 3'b010, 4'b1100, 2'b10);
        def(8'hB6, ZPY, 4'd1, 3'b010, 4'b1100, 2'b10); def(8'hAE, ABS, 4'd1, 3'b010, 4'b1100, 2'b10);
        def(8'hBE, ABY, 4'd1, 3'b010, 4'b1100, 2'b10);
        def(8'hA0, IMM, 4'd1, 3'b100, 4'b1100, 2'b10); def(8'hA4, ZP, 4'd1, 3'b100, 4'b1100, 2'b10);
        def(8'hB4, ZPX, 4'd1, 3'b100, 4'b1100, 2'b10); def(8'hAC, ABS, 4'd1, 3'b100, 4'b1100, 2'b10);
        def(8'hBC, ABX, 4'd1, 3'b100, 4'b1100, 2'b10);
        def(8'h86, ZP, 4'd2, 3'b010, 4'b0, 2'b01); def(8'h96, ZPY, 4'd2, 3'b010, 4'b0, 2'b01);
        def(8'h8E, ABS, 4'd2, 3'b010, 4'b0, 2'b01);
        def(8'h84, ZP, 4'd2, 3'b100, 4'b0, 2'b01); def(8'h94, ZPX, 4'd2, 3'b100, 4'b0, 2'b01);
        def(8'h8C, ABS, 4'd2, 3'b100, 4'b0, 2'b01);
        def(8'hE0, IMM, 4'd9, 3'b010, 4'b1110, 2'b10); def(8'hE4, ZP, 4'd9, 3'b010, 4'b1110, 2'b10);
        def(8'hEC, ABS, 4'd9, 3'b010, 4'b1110, 2'b10);
        def(8'hC0, IMM, 4'd9, 3'b100, 4'b1110, 2'b10); def(8'hC4, ZP, 4'd9, 3'b100, 4'b1110, 2'b10);
        def(8'hCC, ABS, 4'd9, 3'b100, 4'b1110, 2'b10);
        def(8'hAA, IMP, 4'd8, 3'b011, 4'b1100, 2'b00); def(8'hA8, IMP, 4'd8, 3'b101, 4'b1100, 2'b00);
        def(8'h8A, IMP, 4'd8, 3'b011, 4'b1100, 2'b00); def(8'h98, IMP, 4'd8, 3'b101, 4'b1100, 2'b00);
        br = 64'h10_30_50_70_90_B0_D0_F0;
        for (int i = 0; i < 8; i++) def(br[63-8*i -: 8], REL, 4'd6, 3'b000, 4'b0, 2'b10);
        def(8'h4C, ABS, 4'd7, 3'b000, 4'b0, 2'b10); def(8'h6C, IND, 4'd7, 3'b000, 4'b0, 2'b10);
        def(8'h20, ABS, 4'd7, 3'b000, 4'b0, 2'b11); def(8'h60, IMP, 4'd7, 3'b000, 4'b0, 2'b10);
        def(8'h18, IMP, 4'd10, 3'b000, 4'b0010, 2'b00); def(8'h38, IMP, 4'd10, 3'b000, 4'b0010, 2'b00);
        def(8'h48, IMP, 4'd11, 3'b001, 4'b0, 2'b01); def(8'h68, IMP, 4'd11, 3'b001, 4'b1100, 2'b10);
    endtask

    function automatic logic exp_ready();
        return rst_n && !flush && (mq.size() < QD || (mq.size() > 0 && out_ready));
    endfunction

    // Scoreboard: compare mid-cycle, then apply the effect of the coming clock edge to the model.
    always @(negedge clk) begin
        ent_t e;
        logic acc;
        if (!rst_n) begin
            mq.delete();
            part.delete();
        end
        e = (mq.size() > 0) ? mq[0] : ent_t'(0);
        check("mon_ready", 64'(byte_ready), 64'(exp_ready()));
        check("mon_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("mon_count", 64'(count), 64'(mq.size()));
        check("mon_entry", 64'(dut_e), 64'(e));
        if (rst_n) begin
            if (flush) begin
                mq.delete();
                part.delete();
            end else begin
                acc = byte_valid && exp_ready();
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (acc) begin
                    part.push_back(byte_data);
                    if (part.size() == int'(ref_dec[part[0]].len)) begin
                        e = ref_dec[part[0]];
                        if (part.size() > 1) e.opd[7:0]  = part[1];
                        if (part.size() > 2) e.opd[15:8] = part[2];
                        mq.push_back(e);
                        part.delete();
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
    endtask

    initial begin
        build_ref();
        setv(0,  24'hA94200, 2, {8'hA9, 16'h0042, 2'd2, 4'd1,  3'b001, 4'b1100, 2'b10});
        setv(1,  24'h203412, 3, {8'h20, 16'h1234, 2'd3, 4'd7,  3'b000, 4'b0000, 2'b11});
        setv(2,  24'hA80000, 1, {8'hA8, 16'h0000, 2'd1, 4'd8,  3'b101, 4'b1100, 2'b00});
        setv(3,  24'h180000, 1, {8'h18, 16'h0000, 2'd1, 4'd10, 3'b000, 4'b0010, 2'b00});
        setv(4,  24'h020000, 1, {8'h02, 16'h0000, 2'd1, ILL_C, 3'b000, 4'b0000, 2'b00});
        setv(5,  24'h7D0020, 3, {8'h7D, 16'h2000, 2'd3, 4'd3,  3'b011, 4'b1111, 2'b10});
        setv(6,  24'h914400, 2, {8'h91, 16'h0044, 2'd2, 4'd2,  3'b101, 4'b0000, 2'b01});
        setv(7,  24'hD0FE00, 2, {8'hD0, 16'h00FE, 2'd2, 4'd6,  3'b000, 4'b0000, 2'b10});
        setv(8,  24'h480000, 1, {8'h48, 16'h0000, 2'd1, 4'd11, 3'b001, 4'b0000, 2'b01});
        setv(9,  24'hB68000, 2, {8'hB6, 16'h0080, 2'd2, 4'd1,  3'b110, 4'b1100, 2'b10});
        setv(10, 24'hC00500, 2, {8'hC0, 16'h0005, 2'd2, 4'd9,  3'b100, 4'b1110, 2'b10});
        setv(11, 24'h600000, 1, {8'h60, 16'h0000, 2'd1, 4'd7,  3'b000, 4'b0000, 2'b10});
        setv(12, 24'h6C0003, 3, {8'h6C, 16'h0300, 2'd3, 4'd7,  3'b000, 4'b0000, 2'b10});

        #2 rst_n = 1'b0;
        #1;
        check("reset_count", 64'(count), 64'(0));
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_ready", 64'(byte_ready), 64'(0));
        check("reset_entry", 64'(dut_e), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("release_ready", 64'(byte_ready), 64'(1));

        for (int k = 0; k < 13; k++) begin
            out_ready = 1'b0;
            for (int j = 0; j < vecs[k].n; j++) begin
                byte_valid = 1'b1;
                byte_data  = vecs[k].bytes[23-8*j -: 8];
                if (j == vecs[k].n - 1) check($sformatf("vec%0d_pre_valid", k), 64'(out_valid), 64'(0));
                tick();
            end
            byte_valid = 1'b0;
            check($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(1));
            check($sformatf("vec%0d_entry", k), 64'(dut_e), 64'(vecs[k].exp));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Back-pressure: five TAX bytes into a four-deep queue.
        out_ready = 1'b0;
        byte_valid = 1'b1;
        byte_data = 8'hAA;
        repeat (4) tick();
        check("full_count", 64'(count), 64'(4));
        check("full_ready", 64'(byte_ready), 64'(0));
        tick();
        check("stall_count", 64'(count), 64'(4));
        out_ready = 1'b1;
        #1;
        check("full_pop_ready", 64'(byte_ready), 64'(1));
        tick();
        byte_valid = 1'b0;
        out_ready = 1'b0;
        check("pushpop_count", 64'(count), 64'(4));
        check("pushpop_opcode", 64'(out_opcode), 64'(8'hAA));
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("drain_count", 64'(count), 64'(0));

        // Flush with one queued entry and a partial STA abs.
        feed(8'hA9); feed(8'h01); feed(8'h8D);
        byte_data = 8'h00;
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(byte_ready), 64'(0));
        tick();
        flush = 1'b0;
        byte_valid = 1'b0;
        check("flush_count", 64'(count), 64'(0));
        check("flush_valid", 64'(out_valid), 64'(0));
        feed(8'hA8);
        byte_valid = 1'b0;
        check("post_flush_valid", 64'(out_valid), 64'(1));
        check("post_flush_entry", 64'(dut_e), 64'({8'hA8, 16'h0000, 2'd1, 4'd8, 3'b101, 4'b1100, 2'b00}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset between JMP opcode and its operand.
        feed(8'hA9); feed(8'h42); feed(8'h4C);
        byte_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 64'(count), 64'(0));
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_entry", 64'(dut_e), 64'(0));
        check("mid_rst_ready", 64'(byte_ready), 64'(0));
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 64'(byte_ready), 64'(1));
        feed(8'h18);
        byte_valid = 1'b0;
        check("post_rst_valid", 64'(out_valid), 64'(1));
        check("post_rst_entry", 64'(dut_e), 64'({8'h18, 16'h0000, 2'd1, 4'd10, 3'b000, 4'b0010, 2'b00}));
        out_ready = 1'b1;
        tick();

        for (int c = 0; c < 1500; c++) begin
            byte_valid = ($urandom_range(3) != 0);
            byte_data  = 8'($urandom);
            out_ready  = (c < 750) ? ($urandom_range(2) == 0) : ($urandom_range(3) != 0);
            flush      = ($urandom_range(40) == 0);
            tick();
        end
        byte_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        check("final_count", 64'(count), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
